// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared constants, FSM states and queue entry layout for the fetch queue
package inst_fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic {RUN, JALR_WAIT} fq_state_e;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pred;
  } fq_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer with push, pop and flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;

  // entry storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge i_clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: single-outstanding instruction fetcher with predecode, branch prediction and an issue queue
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  output logic            inst_req_out,
  output logic [XLEN-1:0] pc_out,
  input  logic            mem_busy_in,
  input  logic            inst_ready_in,
  input  logic [XLEN-1:0] inst_in,
  output logic [XLEN-1:0] pred_addr_out,
  input  logic            pred_taken_in,
  input  logic            clear_in,
  input  logic [XLEN-1:0] clear_pc_in,
  input  logic            stall_end_in,
  input  logic [XLEN-1:0] jalr_addr_in,
  output logic            deq_valid_out,
  input  logic            deq_ready_in,
  output logic [XLEN-1:0] deq_inst_out,
  output logic [XLEN-1:0] deq_pc_out,
  output logic            deq_pred_out,
  output logic            stall_out
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fq_state_e       r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, w_pc_nx;
  logic            r_pending, w_pending_nx;
  logic            r_drop, w_drop_nx;
  logic [CW-1:0]   w_count;
  fq_entry_t       w_entry, w_head;
  logic            w_is_jal, w_is_jalr, w_is_br, w_pred;
  logic [XLEN-1:0] w_imm_j, w_imm_b, w_next_pc;
  logic            w_req, w_accept;

  assign w_is_jal  = inst_in[6:0] == OP_JAL;
  assign w_is_jalr = inst_in[6:0] == OP_JALR;
  assign w_is_br   = inst_in[6:0] == OP_BRANCH;
  assign w_imm_j   = {{12{inst_in[31]}}, inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
  assign w_imm_b   = {{20{inst_in[31]}}, inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
  assign w_pred    = w_is_jal | (w_is_br & pred_taken_in);
  assign w_next_pc = w_is_jal ? r_pc + w_imm_j : w_pred ? r_pc + w_imm_b : r_pc + XLEN'(4);

  // rst_n_in and rdy_in gate the handshakes so nothing is offered while state cannot move
  assign w_req    = rst_n_in & rdy_in & (r_state == RUN) & ~r_pending & (w_count < CW'(FQ_DEPTH)) &
                    ~mem_busy_in & ~clear_in;
  assign w_accept = r_pending & inst_ready_in & ~r_drop & ~clear_in;

  assign inst_req_out  = w_req;
  assign pc_out        = r_pc;
  assign pred_addr_out = r_pc;
  assign stall_out     = r_state == JALR_WAIT;
  assign deq_valid_out = rdy_in & ~clear_in & (w_count != '0);
  assign deq_inst_out  = w_head.inst;
  assign deq_pc_out    = w_head.pc;
  assign deq_pred_out  = w_head.pred;
  assign w_entry       = '{inst: inst_in, pc: r_pc, pred: w_pred};

  // next state, next pc and outstanding-request bookkeeping; a redirect outranks everything
  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_pending_nx = w_req | (r_pending & ~inst_ready_in);
    w_drop_nx    = r_pending & ~inst_ready_in & (r_drop | clear_in);
    if (clear_in) begin
      w_state_nx = RUN;
      w_pc_nx    = clear_pc_in;
    end else if (w_accept) begin
      w_state_nx = w_is_jalr ? JALR_WAIT : RUN;
      w_pc_nx    = w_next_pc;
    end else if (r_state == JALR_WAIT && stall_end_in) begin
      w_state_nx = RUN;
      w_pc_nx    = jalr_addr_in;
    end
  end

  // control registers, frozen while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_pending <= 1'b0;
      r_drop    <= 1'b0;
    end else if (rdy_in) begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_pending <= w_pending_nx;
      r_drop    <= w_drop_nx;
    end

  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH($bits(fq_entry_t))) u_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_push  (rdy_in & w_accept),
    .i_pop   (deq_valid_out & deq_ready_in),
    .i_flush (rdy_in & clear_in),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_count (w_count)
  );
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, fetch PC after reset.
REQ-003 SHALL have port clk_in  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  in  1  low freezes all state (reset still acts).
REQ-006 SHALL have ports inst_req_out out 1, pc_out out 32: fetch request and address to memory_unit.
REQ-007 SHALL have ports mem_busy_in in 1, inst_ready_in in 1, inst_in in 32: memory busy, response valid, instruction word.
REQ-008 SHALL have ports pred_addr_out out 32, pred_taken_in in 1: predictor query (combinational answer, same cycle).
REQ-009 SHALL have ports clear_in in 1, clear_pc_in in 32: ROB misprediction redirect.
REQ-010 SHALL have ports stall_end_in in 1, jalr_addr_in in 32: JALR target resolved.
REQ-011 SHALL have ports deq_valid_out out 1, deq_ready_in in 1, deq_inst_out out 32, deq_pc_out out 32, deq_pred_out out 1: issue side.
REQ-012 SHALL have port stall_out out 1: high while in JALR_WAIT.

Function
REQ-013 SHALL implement states RUN and JALR_WAIT; reset state RUN.
REQ-014 SHALL assert inst_req_out = RUN && !pending && count<FQ_DEPTH && !mem_busy_in && !clear_in; on assertion, pending<=1.
REQ-015 SHALL hold at most one outstanding request; an inst_ready_in while pending clears pending.
REQ-016 SHALL on accepted response (pending, !drop): enqueue {inst_in, pc, pred}, with pred_addr_out = pc.
REQ-017 SHALL compute next pc: JAL -> pc+immJ (pred=1); B-type with pred_taken_in -> pc+immB (pred=1); B-type not taken -> pc+4 (pred=0); JALR -> pc+4, go JALR_WAIT (pred=0); others -> pc+4.
REQ-018 SHALL sign-extend immediates to 32 bits; all PC arithmetic modulo 2^32.
REQ-019 SHALL in JALR_WAIT issue no requests; on stall_end_in: pc<=jalr_addr_in, state RUN.
REQ-020 SHALL present head entry on deq_* with deq_valid_out = count!=0; pop on deq_valid_out && deq_ready_in.
REQ-021 SHALL support push and pop in the same cycle, count unchanged; pointers wrap modulo FQ_DEPTH; count is clog2(FQ_DEPTH)+1 bits.
REQ-022 SHALL never push when count==FQ_DEPTH (guaranteed by REQ-014).
REQ-023 SHALL on clear_in: empty queue, pc<=clear_pc_in, state RUN; if pending and no response this cycle, set drop.
REQ-024 SHALL with drop set, discard the next inst_ready_in, then clear drop and pending.
REQ-025 SHALL give clear_in priority over stall_end_in, push, pop and response.
REQ-026 SHALL keep deq_valid_out low in the cycle clear_in is high.

Reset
REQ-027 SHALL on rst_n_in low, immediately: pc=RESET_PC, state RUN, count/pointers=0, pending=0, drop=0.
REQ-028 SHALL drive during reset: inst_req_out=0, deq_valid_out=0, stall_out=0, pc_out=RESET_PC; entry storage need not be reset.
REQ-029 SHALL discard any in-flight response after reset deassertion as if drop were set when reset hit mid-request.

Structure
REQ-030 SHALL take opcode constants (JAL, JALR, BRANCH) and XLEN from the shared const package.
REQ-031 SHALL place queue storage in one sub-module fetch_fifo (parametrised depth/width, push/pop/flush).
REQ-032 SHALL place predecode and immediate extraction in the top module as combinational logic.

Verification
REQ-033 Reset, 4 sequential ADDIs at 0x0..0xC, deq_ready_in=1 -> dequeued pcs 0,4,8,C in order, deq_pred_out=0.
REQ-034 deq_ready_in=0, FQ_DEPTH=4 -> after 4 pushes inst_req_out stays 0; raise deq_ready_in -> fetch resumes at 0x10.
REQ-035 JAL +0x40 at 0x8 -> next pc_out 0x48, entry pred=1; BEQ at 0x48, pred_taken_in=1, immB=-8 -> next pc 0x40.
REQ-036 JALR at 0x20 -> stall_out=1, no requests; stall_end_in with 0x100 -> pc_out 0x100, stall_out=0.
REQ-037 clear_in with clear_pc 0x200 while pending and queue holding 3 -> queue empty, stale response dropped, next enqueued pc 0x200.
REQ-038 clear_in and stall_end_in same cycle in JALR_WAIT -> pc=clear_pc_in, state RUN.
